// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is purely combinational on pc_IF; updates from ID commit on the rising edge.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_IF,
    output logic        predict_taken,
    output logic [31:0] predict_PC,
    input  logic        update_valid,
    input  logic [31:0] pc_ID,
    input  logic        predict_taken_ID,
    input  logic [1:0]  predict_state,
    input  logic [31:0] jump_PC,
    output logic [15:0] mispredict_cnt
);
    localparam int TAG_W = 32 - IDX_W - 2;

    logic [ENTRIES-1:0]            valid_q;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
    logic [ENTRIES-1:0][31:0]      target_q;
    logic [ENTRIES-1:0][1:0]       ctr_q;
    logic [15:0]                   cnt_q, cnt_d;

    // Word-aligned PCs: the low two bits carry no information.
    logic unused_pc_lsb;
    assign unused_pc_lsb = &{1'b0, pc_IF[1:0], pc_ID[1:0]};

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    assign f_idx         = pc_IF[IDX_W+1:2];
    assign f_tag         = pc_IF[31:IDX_W+2];
    assign f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign predict_taken = f_hit & ctr_q[f_idx][1];
    assign predict_PC    = predict_taken ? target_q[f_idx] : (pc_IF + 32'd4);

    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit, u_taken, do_upd;
    logic [1:0]       ctr_d;

    assign u_idx   = pc_ID[IDX_W+1:2];
    assign u_tag   = pc_ID[31:IDX_W+2];
    assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign do_upd  = update_valid && (predict_state != 2'b00);
    assign u_taken = (predict_state == 2'b11) || ((predict_state == 2'b01) && predict_taken_ID);

    always_comb begin
        ctr_d = ctr_q[u_idx];
        if (u_taken) begin
            if (ctr_q[u_idx] != 2'b11) ctr_d = ctr_q[u_idx] + 2'd1;
        end else begin
            if (ctr_q[u_idx] != 2'b00) ctr_d = ctr_q[u_idx] - 2'd1;
        end
    end

    // States 10 and 11 are the two direction-mispredict codes.
    assign cnt_d = predict_state[1] ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            tag_q    <= '0;
            target_q <= '0;
            ctr_q    <= {ENTRIES{2'b01}};
            cnt_q    <= '0;
        end else if (do_upd) begin
            cnt_q <= cnt_d;
            if (u_hit) begin
                ctr_q[u_idx] <= ctr_d;
                if (u_taken) target_q[u_idx] <= jump_PC;
            end else if (u_taken) begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= jump_PC;
                ctr_q[u_idx]    <= 2'b10;
            end
        end
    end

    assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor; expected values are hand-derived.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_IF;
    logic        predict_taken;
    logic [31:0] predict_PC;
    logic        update_valid;
    logic [31:0] pc_ID;
    logic        predict_taken_ID;
    logic [1:0]  predict_state;
    logic [31:0] jump_PC;
    logic [15:0] mispredict_cnt;

    int n_vec = 0;
    int n_bad = 0;

    branch_predictor #(.ENTRIES(16), .IDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .pc_IF(pc_IF),
        .predict_taken(predict_taken), .predict_PC(predict_PC),
        .update_valid(update_valid), .pc_ID(pc_ID),
        .predict_taken_ID(predict_taken_ID), .predict_state(predict_state),
        .jump_PC(jump_PC), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic ptid, input logic [1:0] st,
                       input logic [31:0] jpc);
        @(negedge clk);
        update_valid = 1'b1; pc_ID = pc; predict_taken_ID = ptid;
        predict_state = st; jump_PC = jpc;
        @(posedge clk);
        #1 update_valid = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc, input logic exp_t, input logic [31:0] exp_pc,
                        input logic [15:0] exp_cnt, input string tag);
        pc_IF = pc;
        #1;
        chk({tag, ".taken"}, {31'd0, predict_taken}, {31'd0, exp_t});
        chk({tag, ".pc"}, predict_PC, exp_pc);
        chk({tag, ".cnt"}, {16'd0, mispredict_cnt}, {16'd0, exp_cnt});
    endtask

    initial begin
        rst_n = 1'b0; pc_IF = 32'h100; update_valid = 1'b0; pc_ID = '0;
        predict_taken_ID = 1'b0; predict_state = 2'b00; jump_PC = '0;
        #2;
        look(32'h100, 1'b0, 32'h104, 16'd0, "rst");
        look(32'hFFFF_FFFC, 1'b0, 32'h0, 16'd0, "rst_wrap");
        @(negedge clk); rst_n = 1'b1;

        // Allocation on miss + taken
        upd(32'h100, 1'b0, 2'b11, 32'h200);
        look(32'h100, 1'b1, 32'h200, 16'd1, "alloc");
        // 10 -> 01 -> 00
        upd(32'h100, 1'b1, 2'b10, 32'h0);
        look(32'h100, 1'b0, 32'h104, 16'd2, "nt1");
        upd(32'h100, 1'b1, 2'b10, 32'h0);
        look(32'h100, 1'b0, 32'h104, 16'd3, "nt2");
        // Saturate at 00: one taken update must only reach 01
        upd(32'h100, 1'b1, 2'b10, 32'h0);
        upd(32'h100, 1'b0, 2'b11, 32'h200);
        look(32'h100, 1'b0, 32'h104, 16'd5, "sat00");
        upd(32'h100, 1'b0, 2'b11, 32'h200);
        look(32'h100, 1'b1, 32'h200, 16'd6, "back_t");

        // Alias: 0x140 shares index 0 with 0x100
        look(32'h140, 1'b0, 32'h144, 16'd6, "alias_miss");
        upd(32'h140, 1'b0, 2'b11, 32'h500);
        look(32'h140, 1'b1, 32'h500, 16'd7, "alias_new");
        look(32'h100, 1'b0, 32'h104, 16'd7, "alias_old");

        // JALR target correction on a correct taken prediction
        upd(32'h108, 1'b0, 2'b11, 32'h300);
        look(32'h108, 1'b1, 32'h300, 16'd8, "jalr_pre");
        upd(32'h108, 1'b1, 2'b01, 32'h340);
        look(32'h108, 1'b1, 32'h340, 16'd8, "jalr");
        // Saturate at 11: one not-taken update must leave it taken
        upd(32'h108, 1'b1, 2'b01, 32'h340);
        upd(32'h108, 1'b1, 2'b10, 32'h0);
        look(32'h108, 1'b1, 32'h340, 16'd9, "sat11");

        // Same-cycle lookup and update at index 3
        @(negedge clk);
        pc_IF = 32'h10C; update_valid = 1'b1; pc_ID = 32'h10C;
        predict_taken_ID = 1'b0; predict_state = 2'b11; jump_PC = 32'h600;
        #1;
        chk("same.old_t", {31'd0, predict_taken}, 32'd0);
        chk("same.old_pc", predict_PC, 32'h110);
        @(posedge clk);
        #1 update_valid = 1'b0;
        look(32'h10C, 1'b1, 32'h600, 16'd10, "same.new");

        // Blocked updates: update_valid=0, then state 00
        @(negedge clk);
        update_valid = 1'b0; pc_ID = 32'h110; predict_state = 2'b11; jump_PC = 32'h700;
        @(posedge clk); #1;
        look(32'h110, 1'b0, 32'h114, 16'd10, "blk_valid");
        upd(32'h110, 1'b1, 2'b00, 32'h700);
        look(32'h110, 1'b0, 32'h114, 16'd10, "blk_st00");
        upd(32'h10C, 1'b1, 2'b00, 32'h800);
        look(32'h10C, 1'b1, 32'h600, 16'd10, "blk_st00_hit");

        // Miss + not taken: no allocation, still a mispredict
        upd(32'h118, 1'b1, 2'b10, 32'h900);
        look(32'h118, 1'b0, 32'h11C, 16'd11, "miss_nt");

        // Reset mid-operation with an update presented
        @(negedge clk);
        update_valid = 1'b1; pc_ID = 32'h114; predict_taken_ID = 1'b0;
        predict_state = 2'b11; jump_PC = 32'hA00;
        #1 rst_n = 1'b0;
        look(32'h10C, 1'b0, 32'h110, 16'd0, "midrst");
        @(posedge clk);
        @(negedge clk); update_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        look(32'h114, 1'b0, 32'h118, 16'd0, "midrst_drop");
        upd(32'h114, 1'b0, 2'b11, 32'hA00);
        look(32'h114, 1'b1, 32'hA00, 16'd1, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
